// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - Data memory with byte/half/word load-store front end and debug read port.
// One request in flight; the response register turns over every cycle when the consumer keeps up.
module dmem_lsu #(
    parameter int DEPTH     = 256,
    parameter int AW        = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hx;

    // Contents are only set at start-up; reset deliberately leaves the array alone.
    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    state_t          state;
    logic [AW-1:0]   idx;
    logic [1:0]      off;
    logic            legal;
    logic            accept;
    logic            wr_en;
    logic [3:0]      be;
    logic [31:0]     wword;
    logic [31:0]     rd_word;

    assign idx     = req_addr[AW+1:2];
    assign off     = req_addr[1:0];
    assign rd_word = mem[idx];

    // Gating with rstn keeps a store presented on the reset edge from landing in the array.
    assign req_ready = rstn & ((state == IDLE) | resp_ready);
    assign accept    = req_valid & req_ready;
    assign wr_en     = accept & req_we & legal;

    assign dbg_data = mem[dbg_addr[AW-1:0]];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], dbg_addr[31:AW]};

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~off[0];
            3'b010:  legal = (off == 2'b00);
            3'b100:  legal = ~req_we;
            3'b101:  legal = ~req_we & ~off[0];
            default: legal = 1'b0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b0000;
        wword = req_wdata;
        case (req_funct3)
            3'b000: begin
                be    = 4'b0001 << off;
                wword = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wword = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                be    = 4'b1111;
                wword = req_wdata;
            end
            default: begin
                be    = 4'b0000;
                wword = req_wdata;
            end
        endcase
    end

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] o,
                                           input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    // Loads read the array at the acceptance edge, so a store one cycle earlier is already visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= (legal && !req_we) ? extend(rd_word, off, req_funct3) : 32'h0;
                        resp_err   <= ~legal;
                    end
                end
                RESP: begin
                    if (accept) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= (legal && !req_we) ? extend(rd_word, off, req_funct3) : 32'h0;
                        resp_err   <= ~legal;
                    end else if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
